// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the multiplexed 7-segment display controller.
//   - Segment bit positions inside the 8-bit pattern (a..g, dp).
//   - 16-entry hex -> segment glyph table, active-high, bit0 = a ... bit6 = g.
//   - Width helpers used to size counters from parameters.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the glyph for hex digit n (entry 15 is listed first).
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Bits needed to index n items (0..n-1); never narrower than one bit.
  function automatic int width_of(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational glyph generator for one digit.
// Ports:
//   nibble  in  4  hex value to display
//   dp      in  1  decimal point request
//   blank   in  1  suppress segments a..g (leading-zero blanking)
//   pattern out 8  active-high pattern, bit0..6 = a..g, bit7 = dp
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  // Look up the glyph; a blanked digit keeps its decimal point
  always_comb begin
    pattern = 8'h00;
    if (blank) begin
      pattern[SEG_G:SEG_A] = 7'h00;
    end else begin
      pattern[SEG_G:SEG_A] = SEG_HEX[nibble];
    end
    pattern[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed 7-segment scanner with double-buffered writes, leading-zero
// blanking, PWM brightness and a blank guard interval at each dwell start.
// Ports:
//   clk          in   1         system clock
//   rst          in   1         synchronous active-high reset
//   wr_valid     in   1         write request
//   wr_ready     out  1         pending buffer empty
//   wr_data      in   4*DIGITS  hex nibbles, nibble i -> digit i (0 = rightmost)
//   wr_dp        in   DIGITS    decimal point per digit
//   wr_blank_lz  in   1         leading-zero blanking for this write
//   bright       in   BRIGHT_W  brightness, sampled at each dwell start
//   seg7         out  8         a..g in bits 0..6, dp in bit 7
//   seg_cs       out  DIGITS    one-hot digit select
//   frame_done   out  1         pulse during the last cycle of a frame
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_MHZ        = 50,
  parameter int DIGITS         = 4,
  parameter int SCAN_US        = 1000,
  parameter int GUARD_CYC      = CLK_MHZ,
  parameter int BRIGHT_W       = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int CS_ACTIVE_LOW  = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  input  logic                  wr_blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            seg7,
  output logic [DIGITS-1:0]     seg_cs,
  output logic                  frame_done
);

  localparam int DWELL = CLK_MHZ * SCAN_US;
  localparam int CNT_W = width_of(DWELL);
  localparam int IDX_W = width_of(DIGITS);
  // Wide enough for (bright+1)*DWELL before the shift.
  localparam int ONL_W = BRIGHT_W + CNT_W + 2;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] CS_OFF   = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                : {DIGITS{1'b0}};

  // Scan state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                frame_end_s;

  // Write buffers
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_lz_q, pend_lz_d;
  logic                pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                disp_lz_q, disp_lz_d;
  logic                wr_ready_q, wr_ready_d;

  // Output path
  logic [ONL_W-1:0]    on_len_s;
  logic                window_s;
  logic [DIGITS-1:0]   blank_s;
  logic                seen_nz_s;
  logic [3:0]          nib_s;
  logic                dp_s;
  logic                blk_s;
  logic [7:0]          pat_s;
  logic [DIGITS-1:0]   cs_onehot_s;
  logic [7:0]          seg7_q, seg7_d;
  logic [DIGITS-1:0]   seg_cs_q, seg_cs_d;
  logic                frame_done_q, frame_done_d;

  // Dwell counter and digit index; the frame ends on the last digit's last cycle
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_end_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d       = {IDX_W{1'b0}};
        frame_end_s = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Registered from next state so the pulse lines up with the last cycle itself
    frame_done_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // Brightness is taken live at cnt 0 and held for the rest of the dwell
  always_comb begin
    if (cnt_q == {CNT_W{1'b0}}) begin
      bright_d = bright;
    end else begin
      bright_d = bright_q;
    end
    on_len_s = ((ONL_W'(bright_d) + ONL_W'(1)) * ONL_W'(DWELL)) >> BRIGHT_W;
    window_s = (ONL_W'(cnt_q) >= ONL_W'(GUARD_CYC)) && (ONL_W'(cnt_q) < on_len_s);
  end

  // Pending/display double buffer: transfer only at a frame boundary
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    pend_full_d = pend_full_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    disp_lz_d   = disp_lz_q;
    // wr_ready_q implies the pending buffer is empty, so these never collide
    if (frame_end_s && pend_full_q) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      disp_lz_d   = pend_lz_q;
      pend_full_d = 1'b0;
    end else if (wr_valid && wr_ready_q) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_lz_d   = wr_blank_lz;
      pend_full_d = 1'b1;
    end else begin
      pend_full_d = pend_full_q;
    end
    wr_ready_d = ~pend_full_d;
  end

  // Blank zero digits from the most significant end down to the first nonzero one
  always_comb begin
    seen_nz_s = 1'b0;
    blank_s   = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp_data_q[4*i +: 4] != 4'h0) begin
        seen_nz_s = 1'b1;
      end else begin
        seen_nz_s = seen_nz_s;
      end
      if (i == 0) begin
        blank_s[i] = 1'b0;
      end else begin
        blank_s[i] = disp_lz_q & ~seen_nz_s;
      end
    end
  end

  // Select the digit being scanned
  always_comb begin
    nib_s       = disp_data_q[{idx_q, 2'b00} +: 4];
    dp_s        = disp_dp_q[idx_q];
    blk_s       = blank_s[idx_q];
    cs_onehot_s = DIGITS'(1'b1) << idx_q;
  end

  seg7_hex_decode u_decode (
    .nibble  (nib_s),
    .dp      (dp_s),
    .blank   (blk_s),
    .pattern (pat_s)
  );

  // Gate by the PWM window, then apply output polarity (XOR with the idle level)
  always_comb begin
    if (window_s) begin
      seg7_d   = pat_s ^ SEG_OFF;
      seg_cs_d = cs_onehot_s ^ CS_OFF;
    end else begin
      seg7_d   = SEG_OFF;
      seg_cs_d = CS_OFF;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      bright_q     <= {BRIGHT_W{1'b0}};
      pend_data_q  <= {(4*DIGITS){1'b0}};
      pend_dp_q    <= {DIGITS{1'b0}};
      pend_lz_q    <= 1'b0;
      pend_full_q  <= 1'b0;
      disp_data_q  <= {(4*DIGITS){1'b0}};
      disp_dp_q    <= {DIGITS{1'b0}};
      disp_lz_q    <= 1'b0;
      wr_ready_q   <= 1'b0;
      seg7_q       <= SEG_OFF;
      seg_cs_q     <= CS_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_full_q  <= pend_full_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_lz_q    <= disp_lz_d;
      wr_ready_q   <= wr_ready_d;
      seg7_q       <= seg7_d;
      seg_cs_q     <= seg_cs_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign seg7       = seg7_q;
  assign seg_cs     = seg_cs_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with an 8-cycle dwell, 1-cycle guard,
// 4 digits, active-low segments and selects. Timing is referenced to the
// frame_done cycle F: in cycle F+k the outputs show the scan position k-2
// (position = 8*digit + cnt), because outputs lag the scan state by one cycle.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        wr_blank_lz;
  logic [2:0]  bright;
  logic [7:0]  seg7;
  logic [3:0]  seg_cs;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int k_now  = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .CLK_MHZ(1), .DIGITS(4), .SCAN_US(8), .GUARD_CYC(1), .BRIGHT_W(3),
    .SEG_ACTIVE_LOW(1), .CS_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank_lz(wr_blank_lz),
    .bright(bright), .seg7(seg7), .seg_cs(seg_cs), .frame_done(frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k_now++;
  endtask

  task automatic go(input int k);
    while (k_now < k) step();
  endtask

  task automatic show(input string tag, input logic [3:0] exp_cs, input logic [7:0] exp_seg);
    check_val({tag, "_cs"}, 32'(seg_cs), 32'(exp_cs));
    check_val({tag, "_seg"}, 32'(seg7), 32'(exp_seg));
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("frame_wait", 32'(seen), 32'd1);
    k_now = 0;
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    wr_data     = d;
    wr_dp       = dp;
    wr_blank_lz = lz;
    wr_valid    = 1'b1;
    step();
    wr_valid    = 1'b0;
  endtask

  // Count cycles from a release of reset to the first frame_done, checking early outputs
  task automatic after_release(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) check_val({tag, "_ready"}, 32'(wr_ready), 32'd1);
      if (i == 2) show({tag, "_d0"}, 4'b1110, 8'hC0);
      if (frame_done) begin
        n = i;
        break;
      end
    end
    check_val({tag, "_frame_len"}, 32'(n), 32'd31);
    k_now = 0;
  endtask

  initial begin
    int  act;
    int  first;
    int  last;
    bit  rdy_seen;
    bit  found;

    rst = 1'b1; wr_valid = 1'b0; wr_data = 16'h0000; wr_dp = 4'h0;
    wr_blank_lz = 1'b0; bright = 3'd7;

    // Reset state
    repeat (3) step();
    show("rst", 4'hF, 8'hFF);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    after_release("rel");

    // Write in the frame_done cycle: lands in pending, old value still shown next frame
    write(16'h1234, 4'h0, 1'b0);
    check_val("wr_ready_fall", 32'(wr_ready), 32'd0);
    go(3);  show("held_d0", 4'b1110, 8'hC0);
    wait_frame();
    go(1);  check_val("ready_after_xfer", 32'(wr_ready), 32'd1);
    go(2);  show("guard", 4'hF, 8'hFF);
    go(3);  show("h1234_d0", 4'b1110, 8'h99);
    go(11); show("h1234_d1", 4'b1101, 8'hB0);
    go(19); show("h1234_d2", 4'b1011, 8'hA4);
    go(27); show("h1234_d3", 4'b0111, 8'hF9);

    // Leading-zero blanking with a decimal point on a blanked digit
    write(16'h0040, 4'b0100, 1'b1);
    wait_frame();
    go(3);  show("lz_d0", 4'b1110, 8'hC0);
    go(11); show("lz_d1", 4'b1101, 8'h99);
    go(19); show("lz_d2", 4'b1011, 8'h7F);
    go(27); show("lz_d3", 4'b0111, 8'hFF);

    // bright=3: active exactly at cnt 1..3 of digit 0
    bright = 3'd3;
    wait_frame();
    act = 0; first = -1; last = -1;
    for (int k = 2; k <= 9; k++) begin
      go(k);
      if (seg_cs != 4'hF) begin
        act++;
        if (first < 0) first = k;
        last = k;
      end
      if (k == 3) check_val("b3_seg", 32'(seg7), 32'hC0);
    end
    check_val("b3_active", 32'(act), 32'd3);
    check_val("b3_first", 32'(first), 32'd3);
    check_val("b3_last", 32'(last), 32'd5);

    // bright=0: never active for digits 1..3
    bright = 3'd0;
    act = 0;
    for (int k = 10; k <= 33; k++) begin
      go(k);
      if (seg_cs != 4'hF || seg7 != 8'hFF) act++;
    end
    check_val("b0_active", 32'(act), 32'd0);
    bright = 3'd7;

    // Back-to-back writes A then B inside one frame
    wait_frame();
    go(5);
    write(16'h5678, 4'h0, 1'b0);
    wr_data = 16'h9ABC; wr_dp = 4'h0; wr_blank_lz = 1'b0; wr_valid = 1'b1;
    rdy_seen = 1'b0; found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (wr_ready) rdy_seen = 1'b1;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check_val("b_frame_wait", 32'(found), 32'd1);
    check_val("b_held", 32'(rdy_seen), 32'd0);
    k_now = 0;
    step();
    check_val("b_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check_val("b_accepted", 32'(wr_ready), 32'd0);
    go(3);  show("a_d0", 4'b1110, 8'h80);
    go(27); show("a_d3", 4'b0111, 8'h92);
    wait_frame();
    go(3);  show("bb_d0", 4'b1110, 8'hC6);
    go(27); show("bb_d3", 4'b0111, 8'h90);

    // Reset at digit 2 cnt 5 with pending full: pending is discarded
    wait_frame();
    go(3);
    write(16'h2222, 4'h0, 1'b0);
    go(22);
    rst = 1'b1;
    step();
    show("mid_rst", 4'hF, 8'hFF);
    check_val("mid_rst_ready", 32'(wr_ready), 32'd0);
    check_val("mid_rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    after_release("rel2");
    go(3);  show("discard_d0", 4'b1110, 8'hC0);
    go(27); show("discard_d3", 4'b0111, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed 7-segment display controller for the board-level top, succeeding the fixed 4-digit scanner. Drives DIGITS common-cathode/anode digits from a packed hex word, with per-digit decimal points, leading-zero blanking, PWM brightness and an anti-ghosting guard interval. New display values enter through a valid/ready write port and are double-buffered so a frame is never torn.

## Interface
- CLK_MHZ, 50: clock frequency in MHz.
- DIGITS, 4: number of digits, 1..8.
- SCAN_US, 1000: dwell per digit in µs; DWELL = CLK_MHZ*SCAN_US cycles.
- GUARD_CYC, CLK_MHZ: blank cycles at start of each dwell; must be < DWELL.
- BRIGHT_W, 3: brightness field width.
- SEG_ACTIVE_LOW, 1: segment outputs active low.
- CS_ACTIVE_LOW, 1: digit selects active low.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  pending buffer empty.
- wr_data  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost).
- wr_dp  in  DIGITS  decimal point per digit.
- wr_blank_lz  in  1  enable leading-zero blanking for this write.
- bright  in  BRIGHT_W  brightness level, sampled at each dwell start.
- seg7  out  8  bit0..6 = a..g, bit7 = dp.
- seg_cs  out  DIGITS  digit select, one-hot (polarity per CS_ACTIVE_LOW).
- frame_done  out  1  one-cycle pulse at end of last digit's dwell.

## Operation
- Write accepted when wr_valid && wr_ready; data, dp, blank_lz captured into pending buffer; wr_ready falls next cycle.
- At frame boundary (frame_done cycle) a full pending buffer transfers to the display buffer and empties; wr_ready rises the following cycle. Empty pending: display buffer unchanged.
- Scan: digit index 0→DIGITS-1→0; dwell counter 0..DWELL-1; index advances when counter = DWELL-1.
- Active window: GUARD_CYC ≤ cnt < on_len, on_len = ((bright_s+1)*DWELL) >> BRIGHT_W, bright_s sampled at cnt = 0. bright all-ones → window runs to DWELL-1. Outside window: seg_cs and seg7 all inactive.
- Decode 0..F standard hex (active-high codes: 0=3F, 4=66, 8=7F, F=71).
- Leading-zero blanking: scanning from digit DIGITS-1 downward, zero nibbles blanked until first nonzero; digit 0 never blanked. Blanked digit: cs asserted, segments a..g off, dp still shown if set.
- Polarity inversion applied last, on registered outputs.

## Timing
- Reset: seg7 all inactive (FF when active low), seg_cs all inactive, frame_done 0, wr_ready 0 during reset and 1 from first cycle after; index 0, counter 0, both buffers zero, pending empty, blank_lz 0.
- Outputs registered: seg7/seg_cs reflect counter/index state of previous cycle (1-cycle latency).
- frame_done high on cycle with index = DIGITS-1 and cnt = DWELL-1.
- Write and frame boundary in same cycle with pending empty: write lands in pending, not displayed until next boundary.
- New values first visible on digit 0 at cnt = GUARD_CYC of next frame (+1 output latency).
- Reset mid-frame: scan restarts at digit 0, pending data discarded.

## Structure
- Package seg7_pkg: 16-entry hex→segment constant table, segment bit index constants, clog2-based width helpers.
- Sub-module seg7_hex_decode: combinational nibble+dp+blank → 8-bit active-high pattern.
- Top holds write buffers, dwell/index counters, PWM compare, output registers.

## Test plan
Parameters CLK_MHZ=1, SCAN_US=8, GUARD_CYC=1, DIGITS=4, BRIGHT_W=3, active-low both.
- Reset held 3 cycles -> seg7=FF, seg_cs=F, frame_done=0, wr_ready=0; wr_ready=1 on first cycle after release.
- Write 0x1234, dp=0, bright=7 -> after next frame_done, digit 0 window shows seg_cs=1110, seg7=99; digit 3 shows seg_cs=0111, seg7=F9.
- Write 0x0040, blank_lz=1, dp=0100 -> digits 3 seg7=FF, digit 2 seg7=7F (dp only), digit 1 seg7=99, digit 0 seg7=C0.
- bright=3 -> on_len=4; per dwell outputs active exactly cnt 1..3 (3 cycles); bright=0 -> on_len=1, never active.
- Two back-to-back writes A, B within one frame -> B held (wr_ready=0) until cycle after frame_done; A shown next frame, B the frame after.
- Assert rst at cnt=5 of digit 2 with pending full -> outputs inactive next cycle; after release scan starts digit 0, display shows 0 (C0 on digit 0), wr_ready=1.
